// File: rtl/pln_dmem_ctrl.sv
// Data-memory controller: routes one CPU load/store at a time to internal RAM, MMIO registers or a slow external bus.
// Optional macro PLN_DMEM_CTRL_CYCLE_CNT_EN adds the free-running CYCLE register at MMIO offset 0x02.
module pln_dmem_ctrl #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] MMIO_BASE = 16'hFF00,
    parameter int          TIMEOUT   = 15,
    parameter logic [15:0] ERR_DATA  = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_write,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_busy,
    output logic        ext_valid,
    output logic        ext_write,
    output logic [15:0] ext_addr,
    output logic [15:0] ext_wdata,
    input  logic [15:0] ext_rdata,
    input  logic        ext_ready,
    output logic [15:0] gpio_out,
    input  logic [15:0] gpio_in,
    output logic [1:0]  state_dbg
);
    // Handshake: ext_valid rises the cycle after the request edge and holds with ext_* stable until
    // ext_ready is sampled high on a rising edge or TIMEOUT valid cycles elapse; ext_rdata matters only with ext_ready.
    typedef enum logic [1:0] {S_IDLE, S_LOCAL, S_EXT_WAIT, S_RESP} state_t;
    state_t state, state_nxt;

    logic [15:0] ram [2**RAM_AW];
    logic [15:0] rdata_q, gpio_s1, gpio_s2, mmio_rd, cycle_rd;
    logic [7:0]  mmio_off, wait_cnt;
    logic        status_q, is_ram, is_mmio, accept, timeout_hit;

    assign is_ram      = (cpu_addr >> RAM_AW) == 16'd0;
    assign is_mmio     = !is_ram && (cpu_addr >= MMIO_BASE);
    assign mmio_off    = 8'(cpu_addr - MMIO_BASE);
    assign accept      = (state == S_IDLE) && cpu_req;
    assign timeout_hit = wait_cnt == 8'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (cpu_req) state_nxt = (is_ram || is_mmio) ? S_LOCAL : S_EXT_WAIT;
            S_LOCAL:    state_nxt = S_IDLE;
            S_EXT_WAIT: if (ext_ready || timeout_hit) state_nxt = S_RESP;
            S_RESP:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = (state == S_LOCAL) || (state == S_RESP);
        cpu_busy  = (state != S_IDLE);
        ext_valid = (state == S_EXT_WAIT);
        state_dbg = state;
    end

`ifdef PLN_DMEM_CTRL_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cycle_cnt <= '0;
        else      cycle_cnt <= cycle_cnt + 16'd1;
    end
    assign cycle_rd = cycle_cnt;
`else
    assign cycle_rd = '0;
`endif

    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            8'h00:   mmio_rd = gpio_out;
            8'h01:   mmio_rd = gpio_s2;
            8'h02:   mmio_rd = cycle_rd;
            8'h03:   mmio_rd = {15'd0, status_q};
            default: mmio_rd = '0;
        endcase
    end

    // RAM contents survive reset, so the array lives outside the reset domain.
    always_ff @(posedge clk) begin
        if (accept && is_ram && cpu_write) ram[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q   <= '0;
            ext_write <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            gpio_out  <= '0;
            status_q  <= 1'b0;
            wait_cnt  <= '0;
            gpio_s1   <= '0;
            gpio_s2   <= '0;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
            if (accept) begin
                if (is_ram) begin
                    rdata_q <= cpu_write ? 16'd0 : ram[cpu_addr[RAM_AW-1:0]];
                end else if (is_mmio) begin
                    rdata_q <= cpu_write ? 16'd0 : mmio_rd;
                    if (cpu_write && mmio_off == 8'h00) gpio_out <= cpu_wdata;
                    if (cpu_write && mmio_off == 8'h03 && cpu_wdata[0]) status_q <= 1'b0;
                end else begin
                    ext_addr  <= cpu_addr;
                    ext_wdata <= cpu_wdata;
                    ext_write <= cpu_write;
                    wait_cnt  <= '0;
                end
            end else if (state == S_EXT_WAIT) begin
                // ext_ready takes priority over a timeout landing in the same cycle.
                if (ext_ready) begin
                    rdata_q <= ext_rdata;
                end else if (timeout_hit) begin
                    rdata_q  <= ERR_DATA;
                    status_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

    assign cpu_rdata = rdata_q;
endmodule

// File: tb/tb_pln_dmem_ctrl.sv
// Bench for pln_dmem_ctrl: vector table, hand-written corner sequences and randomized ops against a reference model.
module tb_pln_dmem_ctrl;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_write = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata, ext_addr, ext_wdata, gpio_out;
    logic        cpu_ready, cpu_busy, ext_valid, ext_write;
    logic [15:0] ext_rdata = '0, gpio_in = '0;
    logic        ext_ready = 1'b0;
    logic [1:0]  state_dbg;

    pln_dmem_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
        .ext_valid(ext_valid), .ext_write(ext_write), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ready(ext_ready), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // External slave: answers resp_delay cycles after ext_valid rises (-1 = never).
    int          resp_delay = -1, vcnt = 0, vmax = 0;
    logic [15:0] resp_data = '0, addr_seen = '0;
    bit          addr_unstable = 1'b0;
    always @(negedge clk) begin
        if (ext_valid) begin
            if (vcnt == 0) addr_seen = ext_addr;
            else if (ext_addr !== addr_seen) addr_unstable = 1'b1;
            vcnt++;
            if (vcnt > vmax) vmax = vcnt;
            ext_ready = (resp_delay >= 0) && (vcnt == resp_delay + 1);
            ext_rdata = ext_ready ? resp_data : 16'($urandom);
        end else begin
            vcnt      = 0;
            ext_ready = 1'b0;
            ext_rdata = 16'($urandom);
        end
    end

    bit prev_ready = 1'b0;
    always @(negedge clk) begin
        if (cpu_ready) chk_int("ready_single_pulse", int'(prev_ready), 0);
        prev_ready = cpu_ready;
    end

    // Reference model: word-addressed memory and register values.
    logic [15:0] mem_m [int];
    logic [15:0] gpio_m = '0;
    bit          status_m = 1'b0;

    task automatic model(input logic [15:0] a, input logic [15:0] d, input bit w, input int dly,
                         input logic [15:0] xd, output logic [15:0] rd, output int lat, output bit chk_rd);
        int off;
        rd = '0; lat = 1; chk_rd = 1'b1;
        if (a < 16'h0400) begin
            if (w) mem_m[int'(a)] = d;
            else if (mem_m.exists(int'(a))) rd = mem_m[int'(a)];
            else chk_rd = 1'b0;
        end else if (a >= 16'hFF00) begin
            off = int'(a) - 'hFF00;
            if (w) begin
                if (off == 0) gpio_m = d;
                if (off == 3 && d[0]) status_m = 1'b0;
            end else begin
                case (off)
                    0: rd = gpio_m;
                    1: rd = gpio_in;
`ifdef PLN_DMEM_CTRL_CYCLE_CNT_EN
                    2: chk_rd = 1'b0;
`endif
                    3: rd = {15'd0, status_m};
                    default: rd = '0;
                endcase
            end
        end else if (dly >= 0 && dly < TIMEOUT) begin
            lat = dly + 2; rd = xd; chk_rd = !w;
        end else begin
            lat = TIMEOUT + 1; rd = 16'hDEAD; status_m = 1'b1;
        end
    endtask

    task automatic cpu_op(input logic [15:0] a, input logic [15:0] d, input bit w,
                          output logic [15:0] rd, output int lat);
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_write = w; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        lat = 1;
        while (!cpu_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rd = cpu_rdata;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] d, input bit w,
                          input int dly, input logic [15:0] xd);
        logic [15:0] erd, rd;
        int elat, lat;
        bit crd;
        model(a, d, w, dly, xd, erd, elat, crd);
        resp_delay = dly; resp_data = xd;
        cpu_op(a, d, w, rd, lat);
        chk_int({name, "_lat"}, lat, elat);
        if (crd) chk16({name, "_rdata"}, rd, erd);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          write;
        int          dly;
        logic [15:0] xdata;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_vmax;
    } vec_t;
    vec_t tv [20];

    initial begin
        logic [15:0] rd, erd;
        int lat, elat, cat, r;
        bit crd;
        logic [15:0] c0, c1;

        tv[0]  = '{16'h0005, 16'h1234, 1'b1, -1, 16'h0000, 16'h0000, 1, 0};
        tv[1]  = '{16'h0005, 16'h0000, 1'b0, -1, 16'h0000, 16'h1234, 1, 0};
        tv[2]  = '{16'h03FF, 16'hCAFE, 1'b1, -1, 16'h0000, 16'h0000, 1, 0};
        tv[3]  = '{16'h03FF, 16'h0000, 1'b0, -1, 16'h0000, 16'hCAFE, 1, 0};
        tv[4]  = '{16'hFF00, 16'h00A5, 1'b1, -1, 16'h0000, 16'h0000, 1, 0};
        tv[5]  = '{16'hFF00, 16'h0000, 1'b0, -1, 16'h0000, 16'h00A5, 1, 0};
        tv[6]  = '{16'h8000, 16'h0000, 1'b0,  3, 16'hBEEF, 16'hBEEF, 5, 4};
        tv[7]  = '{16'h8000, 16'h0000, 1'b0, -1, 16'h0000, 16'hDEAD, 16, 15};
        tv[8]  = '{16'hFF03, 16'h0000, 1'b0, -1, 16'h0000, 16'h0001, 1, 0};
        tv[9]  = '{16'hFF03, 16'h0001, 1'b1, -1, 16'h0000, 16'h0000, 1, 0};
        tv[10] = '{16'hFF03, 16'h0000, 1'b0, -1, 16'h0000, 16'h0000, 1, 0};
        tv[11] = '{16'hFF03, 16'h0001, 1'b1, -1, 16'h0000, 16'h0000, 1, 0};
        tv[12] = '{16'hFF03, 16'h0000, 1'b0, -1, 16'h0000, 16'h0000, 1, 0};
        tv[13] = '{16'h8000, 16'h0000, 1'b0, 14, 16'h1357, 16'h1357, 16, 15};
        tv[14] = '{16'hFF03, 16'h0000, 1'b0, -1, 16'h0000, 16'h0000, 1, 0};
        tv[15] = '{16'h0400, 16'h0000, 1'b0,  0, 16'h4444, 16'h4444, 2, 1};
        tv[16] = '{16'hFEFF, 16'h0000, 1'b0,  1, 16'h2222, 16'h2222, 3, 2};
        tv[17] = '{16'hFF10, 16'h9999, 1'b1, -1, 16'h0000, 16'h0000, 1, 0};
        tv[18] = '{16'hFF10, 16'h0000, 1'b0, -1, 16'h0000, 16'h0000, 1, 0};
        tv[19] = '{16'hFF01, 16'h0000, 1'b0, -1, 16'h0000, 16'h0000, 1, 0};

        // Reset values
        #12;
        chk16("rst_cpu_ready", {15'd0, cpu_ready}, 16'd0);
        chk16("rst_cpu_busy", {15'd0, cpu_busy}, 16'd0);
        chk16("rst_ext_valid", {15'd0, ext_valid}, 16'd0);
        chk16("rst_ext_write", {15'd0, ext_write}, 16'd0);
        chk16("rst_cpu_rdata", cpu_rdata, 16'd0);
        chk16("rst_ext_addr", ext_addr, 16'd0);
        chk16("rst_ext_wdata", ext_wdata, 16'd0);
        chk16("rst_gpio_out", gpio_out, 16'd0);
        chk16("rst_state", {14'd0, state_dbg}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            model(tv[i].addr, tv[i].wdata, tv[i].write, tv[i].dly, tv[i].xdata, erd, elat, crd);
            resp_delay = tv[i].dly; resp_data = tv[i].xdata;
            vmax = 0; addr_unstable = 1'b0;
            cpu_op(tv[i].addr, tv[i].wdata, tv[i].write, rd, lat);
            chk16($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
            chk_int($sformatf("vec%0d_lat", i), lat, tv[i].exp_lat);
            chk_int($sformatf("vec%0d_ext_valid_cycles", i), vmax, tv[i].exp_vmax);
            chk_int($sformatf("vec%0d_ext_addr_stable", i), int'(addr_unstable), 0);
        end

        // GPIO: output updates at the request edge; input goes through the synchroniser.
        resp_delay = -1;
        model(16'hFF00, 16'h005A, 1'b1, -1, 16'h0, erd, elat, crd);
        cpu_op(16'hFF00, 16'h005A, 1'b1, rd, lat);
        chk16("gpio_out_next_edge", gpio_out, 16'h005A);
        gpio_in = 16'h5A5A;
        repeat (3) @(negedge clk);
        run_op("gpio_in_sync", 16'hFF01, 16'h0, 1'b0, -1, 16'h0);

        // CYCLE register, two loads two cycles apart
        cpu_op(16'hFF02, 16'h0, 1'b0, c0, lat);
        cpu_op(16'hFF02, 16'h0, 1'b0, c1, lat);
`ifdef PLN_DMEM_CTRL_CYCLE_CNT_EN
        chk16("cycle_delta", c1 - c0, 16'd2);
`else
        chk16("cycle_absent_a", c0, 16'd0);
        chk16("cycle_absent_b", c1, 16'd0);
`endif

        // Reset asserted two cycles into an external wait
        run_op("pre_rst_store", 16'h0009, 16'h7777, 1'b1, -1, 16'h0);
        resp_delay = -1;
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_write = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        chk16("mid_ext_valid_before", {15'd0, ext_valid}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk16("mid_rst_ext_valid", {15'd0, ext_valid}, 16'd0);
        chk16("mid_rst_busy", {15'd0, cpu_busy}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk16("mid_rst_no_ready", {15'd0, cpu_ready}, 16'd0);
        end
        rst = 1'b1;
        gpio_m = '0; status_m = 1'b0;
        @(negedge clk);
        chk16("post_rst_no_ready", {15'd0, cpu_ready}, 16'd0);
        run_op("post_rst_ram_load", 16'h0009, 16'h0, 1'b0, -1, 16'h0);

        // cpu_req during an external wait is dropped
        run_op("pre_ign_store", 16'h0001, 16'h1111, 1'b1, -1, 16'h0);
        resp_delay = 4; resp_data = 16'hA0A0;
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_write = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        cpu_addr = 16'h0001; cpu_wdata = 16'hFFFF; cpu_write = 1'b1; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        lat = 0;
        while (!cpu_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk_int("ign_ext_ready_seen", int'(lat < 100), 1);
        chk16("ign_ext_rdata", cpu_rdata, 16'hA0A0);
        run_op("ign_ram_unchanged", 16'h0001, 16'h0, 1'b0, -1, 16'h0);

        // Randomized traffic
        gpio_in = 16'($urandom);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) run_op("rnd_init", 16'(i), 16'($urandom), 1'b1, -1, 16'h0);
        for (int i = 0; i < 80; i++) begin
            cat = $urandom_range(0, 2);
            if (cat == 0) begin
                run_op("rnd_ram", 16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom), -1, 16'h0);
            end else if (cat == 1) begin
                run_op("rnd_mmio", 16'hFF00 + 16'($urandom_range(0, 5)), 16'($urandom), 1'($urandom), -1, 16'h0);
            end else begin
                r = $urandom_range(0, 17);
                run_op("rnd_ext", 16'($urandom_range(16'h0400, 16'hFEFF)), 16'($urandom), 1'($urandom),
                       (r >= TIMEOUT) ? -1 : r, 16'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
